// File: rtl/gpu_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpu_sched_pkg: shared types and header-field decoding for task_dispatcher
// Rev 1.0
// ---------------------------------------------------------------------------
package gpu_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  localparam logic [1:0] FENCE_NONE = 2'b00;
  localparam logic [1:0] FENCE_ACQ  = 2'b01;
  localparam logic [1:0] FENCE_REL  = 2'b10;
  localparam logic [1:0] FENCE_BAD  = 2'b11;

  localparam logic [7:0] IFNUM_MASK  = 8'h3F;
  localparam logic [7:0] FENCE_MASK  = 8'hC0;
  localparam int         FENCE_SHIFT = 6;
  localparam int         HDR_WORDS   = 3;

  function automatic logic [5:0] hdr_count(input logic [7:0] h0);
    return 6'(h0 & IFNUM_MASK);
  endfunction

  function automatic logic [1:0] hdr_fence(input logic [7:0] h0);
    return 2'((h0 & FENCE_MASK) >> FENCE_SHIFT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_pending_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_pending_tracker: per-core busy and acquire-fence masks, dispatch gating
// Rev 1.0
// ---------------------------------------------------------------------------
module core_pending_tracker
  import gpu_sched_pkg::*;
#(
  parameter int CORE_NUM = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                commit,
  input  logic [CORE_NUM-1:0] mask,
  input  logic [1:0]          fence,
  input  logic [CORE_NUM-1:0] core_done,
  output logic [CORE_NUM-1:0] pending,
  output logic                dispatch_ok
);

  logic [CORE_NUM-1:0] pending_q, pending_d;
  logic [CORE_NUM-1:0] acq_q, acq_d;

  always_comb begin
    // A commit setting a bit beats a completion clearing it in the same cycle.
    pending_d = (pending_q & ~core_done) | (commit ? mask : '0);
    acq_d     = acq_q;
    if (commit && (fence == FENCE_ACQ)) begin
      acq_d = mask;
    end else if ((acq_q & pending_q) == '0) begin
      acq_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      acq_q     <= '0;
    end else begin
      pending_q <= pending_d;
      acq_q     <= acq_d;
    end
  end

  assign pending     = pending_q;
  assign dispatch_ok = ((mask & pending_q) == '0) &&
                       ((acq_q & pending_q) == '0) &&
                       ((fence != FENCE_REL) || (pending_q == '0));

endmodule
`default_nettype wire

// File: rtl/task_dispatcher.sv
`default_nettype none
// ---------------------------------------------------------------------------
// task_dispatcher: walks the frame memory and streams frame messages to cores
// Rev 1.0
// ---------------------------------------------------------------------------
module task_dispatcher
  import gpu_sched_pkg::*;
#(
  parameter int PROG_DEPTH = 1024,
  parameter int WORD_W     = 16,
  parameter int CORE_NUM   = 16,
  parameter int MSG_WORDS  = 2,
  parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_we,
  input  logic [ADDR_W-1:0]           load_addr,
  input  logic [WORD_W-1:0]           load_data,
  input  logic                        start,
  input  logic [CORE_NUM-1:0]         core_done,
  output logic                        msg_valid,
  input  logic                        msg_ready,
  output logic [MSG_WORDS*WORD_W-1:0] msg_data,
  output logic [CORE_NUM-1:0]         msg_mask,
  output logic [WORD_W-1:0]           r0_vect,
  output logic                        r0_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int CHK_W = ADDR_W + 8;

  logic [WORD_W-1:0] mem_q [PROG_DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [5:0]            count_q, count_d;
  logic [1:0]            fence_q, fence_d;
  logic [CORE_NUM-1:0]   mask_q, mask_d;
  logic [WORD_W-1:0]     r0_q, r0_d;
  logic [CORE_NUM-1:0]   msg_mask_q, msg_mask_d;
  logic [WORD_W-1:0]     r0_vect_q, r0_vect_d;
  logic                  r0_valid_q, r0_valid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                        mem_we;
  logic [7:0]                  h0_lo;
  logic [CORE_NUM-1:0]         h1_mask;
  logic [WORD_W-1:0]           h2_r0;
  logic [CHK_W-1:0]            frame_end;
  logic                        overflow;
  logic [MSG_WORDS*WORD_W-1:0] payload;
  logic                        commit;
  logic                        dispatch_ok;
  logic [CORE_NUM-1:0]         pending;
  logic [CORE_NUM-1:0]         core_done_s;

  assign mem_we = load_we && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign h0_lo   = mem_q[pc_q][7:0];
  assign h1_mask = mem_q[pc_q + ADDR_W'(1)][CORE_NUM-1:0];
  assign h2_r0   = mem_q[pc_q + ADDR_W'(2)];

  // Widened so a frame near the top of memory cannot wrap past the check.
  assign frame_end = CHK_W'(pc_q) + CHK_W'(HDR_WORDS) +
                     CHK_W'(hdr_count(h0_lo)) * CHK_W'(MSG_WORDS);
  assign overflow  = frame_end > CHK_W'(PROG_DEPTH);

  for (genvar i = 0; i < MSG_WORDS; i++) begin : g_payload
    assign payload[i*WORD_W +: WORD_W] = mem_q[pc_q + ADDR_W'(i)];
  end

  assign commit      = (state_q == ST_WAIT) && dispatch_ok;
  assign core_done_s = (state_q == ST_ERR) ? '0 : core_done;

  core_pending_tracker #(
    .CORE_NUM (CORE_NUM)
  ) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .commit      (commit),
    .mask        (mask_q),
    .fence       (fence_q),
    .core_done   (core_done_s),
    .pending     (pending),
    .dispatch_ok (dispatch_ok)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    fence_d    = fence_q;
    mask_d     = mask_q;
    r0_d       = r0_q;
    msg_mask_d = msg_mask_q;
    r0_vect_d  = r0_vect_q;
    r0_valid_d = 1'b0;
    done_d     = done_q;
    err_d      = err_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_FETCH: begin
        count_d = hdr_count(h0_lo);
        fence_d = hdr_fence(h0_lo);
        mask_d  = h1_mask;
        r0_d    = h2_r0;
        if ((hdr_fence(h0_lo) == FENCE_BAD) || overflow) begin
          state_d    = ST_ERR;
          err_d      = 1'b1;
          msg_mask_d = '0;
          r0_vect_d  = '0;
        end else if (hdr_count(h0_lo) == 6'd0) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dispatch_ok) begin
          msg_mask_d = mask_q;
          r0_vect_d  = r0_q;
          r0_valid_d = 1'b1;
          pc_d       = pc_q + ADDR_W'(HDR_WORDS);
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (msg_ready) begin
          pc_d    = pc_q + ADDR_W'(MSG_WORDS);
          count_d = count_q - 6'd1;
          if (count_q == 6'd1) begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_DRAIN: begin
        if (pending == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      count_q    <= '0;
      fence_q    <= '0;
      mask_q     <= '0;
      r0_q       <= '0;
      msg_mask_q <= '0;
      r0_vect_q  <= '0;
      r0_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      fence_q    <= fence_d;
      mask_q     <= mask_d;
      r0_q       <= r0_d;
      msg_mask_q <= msg_mask_d;
      r0_vect_q  <= r0_vect_d;
      r0_valid_q <= r0_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign msg_valid = (state_q == ST_SEND);
  assign msg_data  = (state_q == ST_SEND) ? payload : '0;
  assign msg_mask  = msg_mask_q;
  assign r0_vect   = r0_vect_q;
  assign r0_valid  = r0_valid_q;
  assign busy      = state_q inside {ST_FETCH, ST_WAIT, ST_SEND, ST_DRAIN};
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_task_dispatcher.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_task_dispatcher: randomized program runs against a program-interpreting
// reference model, plus fence, error-boundary and reset-mid-send scenarios
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_task_dispatcher;
  import gpu_sched_pkg::*;

  localparam int DEPTH = 1024;
  localparam int WW    = 16;
  localparam int CN    = 16;
  localparam int MW    = 2;
  localparam int AW    = 10;

  logic             clk = 1'b0;
  logic             reset, load_we, start, msg_ready;
  logic [AW-1:0]    load_addr;
  logic [WW-1:0]    load_data;
  logic [CN-1:0]    core_done;
  logic             msg_valid, r0_valid, busy, done, err;
  logic [MW*WW-1:0] msg_data;
  logic [CN-1:0]    msg_mask;
  logic [WW-1:0]    r0_vect;

  always #5 clk = ~clk;

  task_dispatcher #(
    .PROG_DEPTH (DEPTH),
    .WORD_W     (WW),
    .CORE_NUM   (CN),
    .MSG_WORDS  (MW),
    .ADDR_W     (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .core_done (core_done),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_data  (msg_data),
    .msg_mask  (msg_mask),
    .r0_vect   (r0_vect),
    .r0_valid  (r0_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: interprets the program image frame by frame, with
  // pipeline latencies expressed as the earliest clock edge an action may occur.
  localparam int P_IDLE = 0, P_WAIT = 1, P_SEND = 2, P_DRAIN = 3, P_DONE = 4, P_ERR = 5;

  logic [15:0] img [DEPTH];
  int          ph = P_IDLE;
  int          edge_n = 0;
  int          rdy_edge = 0;
  int          m_pc = 0;
  int          left = 0;
  int          f_cnt = 0;
  logic [1:0]  f_fence = '0;
  logic [15:0] f_mask = '0, f_r0 = '0;
  logic [15:0] m_pend = '0, m_acq = '0, m_mmask = '0, m_r0 = '0;
  logic        m_r0v = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [15:0] prog [$];

  task automatic schedule();
    logic [15:0] h0;
    int          cnt;
    logic [1:0]  fn;
    h0  = img[m_pc % DEPTH];
    cnt = int'(h0[5:0]);
    fn  = h0[7:6];
    if (fn == 2'b11 || m_pc + 3 + cnt * MW > DEPTH) begin
      ph = P_ERR;
      rdy_edge = edge_n + 1;
    end else if (cnt == 0) begin
      ph = P_DRAIN;
      rdy_edge = edge_n + 2;
    end else begin
      ph       = P_WAIT;
      rdy_edge = edge_n + 2;
      f_cnt    = cnt;
      f_fence  = fn;
      f_mask   = img[(m_pc + 1) % DEPTH];
      f_r0     = img[(m_pc + 2) % DEPTH];
    end
  endtask

  task automatic model_edge(input logic rs, input logic st, input logic rdy,
                            input logic [15:0] cd, input logic we, input int wa,
                            input logic [15:0] wd);
    logic [15:0] pp, ap;
    logic        pre_err;
    pp      = m_pend;
    ap      = m_acq;
    pre_err = (ph == P_ERR) && m_err;
    m_r0v   = 1'b0;
    edge_n++;
    if (rs) begin
      ph = P_IDLE; m_pend = '0; m_acq = '0; m_mmask = '0; m_r0 = '0;
      m_done = 1'b0; m_err = 1'b0; m_pc = 0;
      return;
    end
    if (we && (ph == P_IDLE || ph == P_DONE || pre_err)) img[wa] = wd;
    case (ph)
      P_IDLE, P_DONE: if (st) begin m_done = 1'b0; m_pc = 0; schedule(); end
      P_WAIT: begin
        if (edge_n >= rdy_edge && (f_mask & pp) == 0 && (ap & pp) == 0 &&
            (f_fence != FENCE_REL || pp == 0)) begin
          m_mmask = f_mask; m_r0 = f_r0; m_r0v = 1'b1;
          m_pc += 3; left = f_cnt; ph = P_SEND;
        end
      end
      P_SEND: if (rdy) begin m_pc += MW; left--; if (left == 0) schedule(); end
      P_DRAIN: if (edge_n >= rdy_edge && pp == 0) begin ph = P_DONE; m_done = 1'b1; end
      P_ERR: if (!m_err && edge_n >= rdy_edge) begin m_err = 1'b1; m_mmask = '0; m_r0 = '0; end
      default: ;
    endcase
    if (!pre_err) begin
      m_pend = (pp & ~cd) | (m_r0v ? f_mask : 16'h0);
      if (m_r0v && f_fence == FENCE_ACQ) m_acq = f_mask;
      else if ((ap & pp) == 0) m_acq = '0;
    end
  endtask

  task automatic compare();
    logic        exp_send, exp_busy;
    logic [31:0] ed;
    exp_send = (ph == P_SEND);
    exp_busy = (ph == P_WAIT || ph == P_SEND || ph == P_DRAIN || (ph == P_ERR && !m_err));
    ed = exp_send ? {img[(m_pc + 1) % DEPTH], img[m_pc % DEPTH]} : 32'h0;
    check("msg_valid", 64'(msg_valid), 64'(exp_send));
    check("msg_data",  64'(msg_data),  64'(ed));
    check("msg_mask",  64'(msg_mask),  64'(m_mmask));
    check("r0_vect",   64'(r0_vect),   64'(m_r0));
    check("r0_valid",  64'(r0_valid),  64'(m_r0v));
    check("busy",      64'(busy),      64'(exp_busy));
    check("done",      64'(done),      64'(m_done));
    check("err",       64'(err),       64'(m_err));
  endtask

  task automatic step(input logic rs, input logic st, input logic rdy, input logic [15:0] cd,
                      input logic we, input int wa, input logic [15:0] wd);
    reset = rs; start = st; msg_ready = rdy; core_done = cd;
    load_we = we; load_addr = AW'(wa); load_data = wd;
    @(posedge clk);
    @(negedge clk);
    model_edge(rs, st, rdy, cd, we, wa, wd);
    compare();
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, i, prog[i]);
  endtask

  task automatic run_prog(input int max_cyc, input bit fixed);
    int          n;
    logic        rdy, st, we;
    logic [15:0] cd;
    n = 0;
    step(1'b0, 1'b1, 1'b1, 16'h0, 1'b0, 0, 16'h0);
    while (!(ph == P_DONE || (ph == P_ERR && m_err)) && n < max_cyc) begin
      rdy = fixed ? 1'b1 : 1'($urandom_range(0, 1));
      cd  = 16'($urandom & $urandom) & 16'h001F;
      st  = fixed ? 1'b0 : ($urandom_range(0, 7) == 0);
      we  = fixed ? 1'b0 : ($urandom_range(0, 7) == 0);
      step(1'b0, st, rdy, cd, we, int'($urandom_range(0, prog.size() - 1)), 16'($urandom));
      n++;
    end
    check("run_bound", 64'(n < max_cyc), 64'd1);
  endtask

  task automatic add_frame(input int cnt, input logic [1:0] fn, input logic [15:0] mask);
    prog.push_back({8'($urandom), fn, 6'(cnt)});
    prog.push_back(mask);
    prog.push_back(16'($urandom));
    for (int k = 0; k < cnt * MW; k++) prog.push_back(16'($urandom));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) img[i] = '0;
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0, 16'h0);

    // Basic two-beat frame followed by end-of-program marker.
    prog = '{16'h0002, 16'h0003, 16'h00AA, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0000};
    load_prog();
    run_prog(300, 1'b1);

    // Shared-core conflict, acquire then disjoint frame, release frame.
    prog.delete();
    add_frame(1, FENCE_NONE, 16'h0001);
    add_frame(2, FENCE_NONE, 16'h0003);
    add_frame(1, FENCE_ACQ,  16'h0001);
    add_frame(1, FENCE_NONE, 16'h0002);
    add_frame(3, FENCE_REL,  16'h0004);
    prog.push_back(16'h0000);
    load_prog();
    run_prog(600, 1'b0);

    // Illegal fence: error right after fetch, start ignored until reset.
    prog = '{16'h00C1, 16'h0001, 16'h0055, 16'hAAAA, 16'hBBBB, 16'h0000};
    load_prog();
    run_prog(50, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 16'h000F, 1'b0, 0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0, 16'h0);

    // Frame that would run past the end of memory, reached at pc = 1000.
    prog.delete();
    for (int f = 0; f < 7; f++) add_frame(63, FENCE_NONE, 16'h0000);
    add_frame(47, FENCE_NONE, 16'h0000);
    prog.push_back(16'h003F);
    prog.push_back(16'h0001);
    prog.push_back(16'h0002);
    load_prog();
    run_prog(3000, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0, 16'h0);

    // Reset while a beat is being offered.
    prog.delete();
    add_frame(3, FENCE_NONE, 16'h0001);
    prog.push_back(16'h0000);
    load_prog();
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 0, 16'h0);
    for (int k = 0; k < 10 && ph != P_SEND; k++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 0, 16'h0);
    check("send_reached", 64'(msg_valid), 64'd1);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 0, 16'h0);
    step(1'b1, 1'b0, 1'b1, 16'h0, 1'b0, 0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 0, 16'h0);

    // Randomized programs.
    for (int p = 0; p < 40; p++) begin
      int nf;
      prog.delete();
      nf = int'($urandom_range(1, 4));
      for (int f = 0; f < nf; f++)
        add_frame(int'($urandom_range(1, 4)),
                  ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                  16'($urandom_range(0, 15)));
      prog.push_back({8'($urandom), 2'($urandom_range(0, 2)), 6'd0});
      load_prog();
      run_prog(1000, 1'b0);
      if (m_err) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 0, 16'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
